// File: rtl/conv_out_collector.sv
// Frame sink for the 3x3 convolution output stream: optional ReLU, raster-order
// frame-buffer writes, running IEEE-754 frame maximum and a frame-done pulse.
module conv_out_collector #(
    parameter int          DATA_WIDTH = 32,
    parameter int          IMG_SIZE   = 100,
    parameter int          ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          RELU_EN    = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] frame_max,
    output logic                  err_overflow
);

    localparam int                    OUT_SIZE = IMG_SIZE - 2;
    localparam int                    CNT_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(OUT_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] NEG_INF  = DATA_WIDTH'(32'hFF80_0000);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      row, col;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [DATA_WIDTH-1:0] proc_data;
    logic                  accept, last_accept, is_nan;

    // IEEE ordering with +0 == -0; callers exclude NaN beforehand.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] a_mag, b_mag;
        a_mag = a[DATA_WIDTH-2:0];
        b_mag = b[DATA_WIDTH-2:0];
        case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
            2'b00:   return a_mag > b_mag;
            2'b11:   return a_mag < b_mag;
            2'b01:   return (a_mag != '0) || (b_mag != '0);
            default: return 1'b0;
        endcase
    endfunction

    assign proc_data   = ((RELU_EN != 0) && data_in[DATA_WIDTH-1]) ? '0 : data_in;
    assign is_nan      = (&proc_data[30:23]) && (|proc_data[22:0]);
    assign accept      = (state == COLLECT) && valid_in;
    assign last_accept = accept && (row == LAST_IDX) && (col == LAST_IDX);
    assign busy        = (state == COLLECT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)       next_state = COLLECT;
            COLLECT: if (last_accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            frame_done   <= 1'b0;
            frame_max    <= NEG_INF;
            err_overflow <= 1'b0;
            row          <= '0;
            col          <= '0;
            addr_cnt     <= '0;
        end else begin
            mem_we     <= accept;
            frame_done <= last_accept;

            if (state == IDLE) begin
                if (start) begin
                    row       <= '0;
                    col       <= '0;
                    addr_cnt  <= BASE;
                    frame_max <= NEG_INF;
                end
                // A pixel arriving with start is still dropped, so the set wins over the clear.
                if (valid_in)   err_overflow <= 1'b1;
                else if (start) err_overflow <= 1'b0;
            end

            if (accept) begin
                mem_addr <= addr_cnt;
                mem_data <= proc_data;
                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
                if (!is_nan && fp_gt(proc_data, frame_max))
                    frame_max <= proc_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench: two collectors (ReLU off / on) on shared stimulus, 3x3 output frame.
module tb_conv_out_collector;

    localparam int          NPIX    = 9;
    localparam logic [15:0] BASE    = 16'h0100;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid_in = 1'b0;
    logic [31:0] data_in = '0;

    logic        p_we, p_busy, p_done, p_err, r_we, r_busy, r_done, r_err;
    logic [15:0] p_addr, r_addr;
    logic [31:0] p_data, p_max, r_data, r_max;

    int checks = 0;
    int errors = 0;

    logic [31:0] px [NPIX];
    int          gap[NPIX];

    always #5 clk = ~clk;

    conv_out_collector #(.DATA_WIDTH(32), .IMG_SIZE(5), .ADDR_WIDTH(16),
                         .BASE_ADDR(32'h0100), .RELU_EN(0)) u_plain (
        .Clk(clk), .Rst(rst_n), .start(start), .valid_in(valid_in), .data_in(data_in),
        .mem_we(p_we), .mem_addr(p_addr), .mem_data(p_data), .busy(p_busy),
        .frame_done(p_done), .frame_max(p_max), .err_overflow(p_err));

    conv_out_collector #(.DATA_WIDTH(32), .IMG_SIZE(5), .ADDR_WIDTH(16),
                         .BASE_ADDR(32'h0100), .RELU_EN(1)) u_relu (
        .Clk(clk), .Rst(rst_n), .start(start), .valid_in(valid_in), .data_in(data_in),
        .mem_we(r_we), .mem_addr(r_addr), .mem_data(r_data), .busy(r_busy),
        .frame_done(r_done), .frame_max(r_max), .err_overflow(r_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] f);
        return f[31] ? 32'h0 : f;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " p_we"},   p_we,   0);  check({tag, " r_we"},   r_we,   0);
        check({tag, " p_addr"}, p_addr, 0);  check({tag, " p_data"}, p_data, 0);
        check({tag, " p_busy"}, p_busy, 0);  check({tag, " r_busy"}, r_busy, 0);
        check({tag, " p_done"}, p_done, 0);  check({tag, " p_err"},  p_err,  0);
        check({tag, " p_max"},  p_max,  NEG_INF);
        check({tag, " r_max"},  r_max,  NEG_INF);
    endtask

    task automatic do_start(input logic with_valid);
        @(negedge clk);
        start    = 1'b1;
        valid_in = with_valid;
        data_in  = 32'h3F80_0000;
        @(negedge clk);
        start    = 1'b0;
        valid_in = 1'b0;
        check("start busy",  p_busy, 1);
        check("start we",    p_we,   0);
        check("start err",   p_err,  with_valid);
        check("start max",   p_max,  NEG_INF);
    endtask

    // Starts and ends on a falling edge with valid_in low.
    task automatic run_frame(input string tag, input logic [31:0] max_p, input logic [31:0] max_r);
        for (int i = 0; i < NPIX; i++) begin
            valid_in = 1'b1;
            data_in  = px[i];
            @(negedge clk);
            valid_in = 1'b0;
            data_in  = 32'hDEAD_BEEF;
            check({tag, " p_we"},   p_we,   1);
            check({tag, " p_addr"}, p_addr, 32'(BASE + 16'(i)));
            check({tag, " p_data"}, p_data, px[i]);
            check({tag, " r_addr"}, r_addr, 32'(BASE + 16'(i)));
            check({tag, " r_data"}, r_data, relu(px[i]));
            check({tag, " p_done"}, p_done, (i == NPIX - 1));
            check({tag, " r_done"}, r_done, (i == NPIX - 1));
            check({tag, " p_busy"}, p_busy, (i != NPIX - 1));
            if (i != NPIX - 1) begin
                for (int g = 0; g < gap[i]; g++) begin
                    @(negedge clk);
                    check({tag, " gap we"},   p_we,   0);
                    check({tag, " gap done"}, p_done, 0);
                end
            end
        end
        check({tag, " p_max"}, p_max, max_p);
        check({tag, " r_max"}, r_max, max_r);
        @(negedge clk);
        check({tag, " tail we"},   p_we,   0);
        check({tag, " tail done"}, p_done, 0);
        check({tag, " tail busy"}, p_busy, 0);
        check({tag, " tail addr"}, p_addr, 32'(BASE + 16'(NPIX - 1)));
        check({tag, " tail max"},  p_max,  max_p);
    endtask

    initial begin
        gap = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Ascending 1.0 .. 9.0, back-to-back.
        px = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
               32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};
        do_start(1'b0);
        run_frame("seq", 32'h4110_0000, 32'h4110_0000);

        // Same frame with idle gaps between pixels.
        gap = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        do_start(1'b0);
        run_frame("gaps", 32'h4110_0000, 32'h4110_0000);
        gap = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Negatives and -0.0 through the ReLU.
        px = '{32'hC000_0000, 32'h8000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        do_start(1'b0);
        run_frame("relu", 32'h3F00_0000, 32'h3F00_0000);

        // All-negative frame: the smallest magnitude wins.
        px = '{32'hC040_0000, 32'hBF80_0000, 32'hC0A0_0000, 32'hC000_0000, 32'hC080_0000,
               32'hC0C0_0000, 32'hC0E0_0000, 32'hC100_0000, 32'hC110_0000};
        do_start(1'b0);
        run_frame("neg", 32'hBF80_0000, 32'h0000_0000);

        // NaN is written but never becomes the maximum.
        px = '{32'h3F80_0000, 32'h7FC0_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000,
               32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000};
        do_start(1'b0);
        run_frame("nan", 32'h4000_0000, 32'h4000_0000);

        // -0.0 first, then +0.0: equal, so the maximum keeps -0.0.
        px = '{32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000,
               32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000};
        do_start(1'b0);
        run_frame("zero", 32'h8000_0000, 32'h0000_0000);

        // Stray pixel in IDLE: dropped, sticky error, cleared by the next start.
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = 32'h4000_0000;
        @(negedge clk);
        valid_in = 1'b0;
        check("ovf we",    p_we,   0);
        check("ovf p_err", p_err,  1);
        check("ovf r_err", r_err,  1);
        check("ovf addr",  p_addr, 32'(BASE + 16'(NPIX - 1)));
        repeat (2) @(negedge clk);
        check("ovf sticky", p_err, 1);
        px = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
               32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};
        do_start(1'b0);
        run_frame("after ovf", 32'h4110_0000, 32'h4110_0000);

        // start and valid_in together: frame arms, pixel dropped, error set.
        do_start(1'b1);
        run_frame("start+valid", 32'h4110_0000, 32'h4110_0000);
        check("start+valid err kept", p_err, 1);

        // Reset after four pixels abandons the frame.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = px[i];
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("pre-reset we", p_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0);
        run_frame("post reset", 32'h4110_0000, 32'h4110_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
